// File: rtl/ws_pkg.sv
// rtl/ws_pkg.sv - shared FSM encoding and default geometry for the weight-stationary scheduler
package ws_pkg;

    localparam int def_size      = 4;
    localparam int def_bit_width = 8;
    localparam int def_acc_width = 32;

    localparam logic [2:0] st_idle    = 3'd0;
    localparam logic [2:0] st_load    = 3'd1;
    localparam logic [2:0] st_compute = 3'd2;
    localparam logic [2:0] st_drain   = 3'd3;
    localparam logic [2:0] st_done    = 3'd4;

endpackage

// File: rtl/ws_skew_buf.sv
// rtl/ws_skew_buf.sv - per-lane diagonal delay line; lane i is delayed i+1 cycles
module ws_skew_buf #(
    parameter int size      = 4,
    parameter int bit_width = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [size*bit_width-1:0] row,
    output logic [size*bit_width-1:0] skewed
);

    for (genvar i = 0; i < size; i++) begin : g_lane
        logic [bit_width-1:0] pipe [0:i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) pipe[j] <= '0;
            end else if (enable) begin
                pipe[0] <= row[i*bit_width +: bit_width];
                for (int j = 1; j <= i; j++) pipe[j] <= pipe[j-1];
            end
        end

        assign skewed[i*bit_width +: bit_width] = pipe[i];
    end

endmodule

// File: rtl/ws_sched4x4.sv
// rtl/ws_sched4x4.sv - job scheduler feeding weights and skewed data rows into a systolic array
module ws_sched4x4
    import ws_pkg::*;
#(
    parameter int size      = def_size,
    parameter int bit_width = def_bit_width,
    parameter int acc_width = def_acc_width,
    parameter int lat       = 2*size
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                num_rows,
    input  logic                      wt_valid,
    output logic                      wt_ready,
    input  logic [size*bit_width-1:0] wt_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [size*bit_width-1:0] data_in,
    output logic                      arr_control,
    output logic [size*bit_width-1:0] arr_wt,
    output logic [size*bit_width-1:0] arr_data,
    input  logic [acc_width*size-1:0] arr_acc,
    output logic                      res_valid,
    output logic [acc_width*size-1:0] res_data,
    output logic                      busy,
    output logic                      done
);

    logic [2:0]     state;
    logic [7:0]     nrows_q;
    logic [7:0]     wt_cnt;
    logic [7:0]     row_cnt;
    logic [7:0]     res_cnt;
    logic [lat-1:0] vpipe;
    logic           wt_beat;
    logic           data_beat;

    assign wt_ready    = (state == st_load);
    assign data_ready  = (state == st_compute) && (row_cnt != nrows_q);
    assign wt_beat     = wt_valid && wt_ready;
    assign data_beat   = data_valid && data_ready;
    assign arr_control = wt_beat;
    assign arr_wt      = wt_beat ? wt_in : '0;
    assign busy        = (state != st_idle);
    assign done        = (state == st_done);
    assign res_valid   = vpipe[lat-1];

    // Non-beat cycles push an all-zero bubble so row spacing survives the skew.
    ws_skew_buf #(
        .size      (size),
        .bit_width (bit_width)
    ) u_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (busy),
        .row    (data_beat ? data_in : '0),
        .skewed (arr_data)
    );

    // vpipe[k] marks a data beat accepted k+1 cycles ago; the last bit is res_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpipe    <= '0;
            res_data <= '0;
        end else begin
            vpipe    <= {vpipe[lat-2:0], data_beat};
            res_data <= vpipe[lat-2] ? arr_acc : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= st_idle;
            nrows_q <= '0;
            wt_cnt  <= '0;
            row_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (state != st_idle && vpipe[lat-2]) res_cnt <= res_cnt + 8'd1;
            case (state)
                st_idle: begin
                    if (start) begin
                        nrows_q <= num_rows;
                        wt_cnt  <= '0;
                        row_cnt <= '0;
                        res_cnt <= '0;
                        state   <= st_load;
                    end
                end
                st_load: begin
                    if (wt_beat) begin
                        wt_cnt <= wt_cnt + 8'd1;
                        if (wt_cnt == 8'(size - 1))
                            state <= (nrows_q != 8'd0) ? st_compute : st_done;
                    end
                end
                st_compute: begin
                    if (data_beat) begin
                        row_cnt <= row_cnt + 8'd1;
                        if (row_cnt == nrows_q - 8'd1) state <= st_drain;
                    end
                end
                st_drain: begin
                    if (res_cnt == nrows_q) state <= st_done;
                end
                st_done: state <= st_idle;
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_ws_sched4x4.sv
// tb/tb_ws_sched4x4.sv - directed vector bench for ws_sched4x4
module tb_ws_sched4x4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   num_rows;
    logic         wt_valid;
    logic         wt_ready;
    logic [31:0]  wt_in;
    logic         data_valid;
    logic         data_ready;
    logic [31:0]  data_in;
    logic         arr_control;
    logic [31:0]  arr_wt;
    logic [31:0]  arr_data;
    logic [127:0] arr_acc;
    logic         res_valid;
    logic [127:0] res_data;
    logic         busy;
    logic         done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ws_sched4x4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_rows    (num_rows),
        .wt_valid    (wt_valid),
        .wt_ready    (wt_ready),
        .wt_in       (wt_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_in     (data_in),
        .arr_control (arr_control),
        .arr_wt      (arr_wt),
        .arr_data    (arr_data),
        .arr_acc     (arr_acc),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic        wv;
        logic [31:0] wt;
        logic        exp_ctrl;
        logic [31:0] exp_wt;
        logic        exp_wready;
        logic        exp_dready;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dot(input logic [31:0] d, input logic [31:0] w);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 4; i++) s = s + 32'(d[8*i +: 8]) * 32'(w[8*i +: 8]);
        return s;
    endfunction

    task automatic start_job(input logic [7:0] n);
        start    = 1'b1;
        num_rows = n;
        step();
        start    = 1'b0;
    endtask

    task automatic load4();
        wt_valid = 1'b1;
        wt_in    = 32'h01010101;
        repeat (4) step();
        wt_valid = 1'b0;
    endtask

    // One data beat, then watch skew, result timing and done for ten cycles.
    task automatic beat_watch(input logic [31:0] row, input logic skew_chk);
        logic [31:0] d;
        logic [31:0] lane_mask;
        d          = dot(row, 32'h01010101);
        arr_acc    = {4{d}};
        data_valid = 1'b1;
        data_in    = row;
        #1;
        chk("data_ready_at_beat", data_ready, 1'b1);
        step();
        data_valid = 1'b0;
        data_in    = '0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("res_valid_k%0d", k), res_valid, k == 7);
            if (k == 7) chk("res_data", res_data, {4{d}});
            chk($sformatf("done_k%0d", k), done, k == 8);
            if (skew_chk) begin
                lane_mask = 32'hFF << (8*k);
                chk($sformatf("arr_data_k%0d", k), arr_data, (k < 4) ? (row & lane_mask) : 32'h0);
            end
            if (k == 9) chk("busy_after_done", busy, 1'b0);
            step();
        end
    endtask

    initial begin
        vec_t        vt [8];
        logic        prev_dv;
        logic        dv;
        logic        any_bad;
        int          nres;
        int          ndone;

        vt[0] = '{1'b1, 32'h01010101, 1'b1, 32'h01010101, 1'b1, 1'b0};
        vt[1] = '{1'b0, 32'h01010101, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[2] = '{1'b1, 32'h01010101, 1'b1, 32'h01010101, 1'b1, 1'b0};
        vt[3] = '{1'b0, 32'h01010101, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[4] = '{1'b1, 32'h01010101, 1'b1, 32'h01010101, 1'b1, 1'b0};
        vt[5] = '{1'b0, 32'h01010101, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[6] = '{1'b1, 32'h01010101, 1'b1, 32'h01010101, 1'b1, 1'b0};
        vt[7] = '{1'b1, 32'h01010101, 1'b0, 32'h00000000, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; num_rows = '0; wt_valid = 1'b0; wt_in = '0;
        data_valid = 1'b0; data_in = '0; arr_acc = '0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_outputs", {arr_control, arr_wt, arr_data, res_valid, done, wt_ready, data_ready}, '0);
        chk("rst_res_data", res_data, '0);
        rst_n = 1'b1;
        step();

        // Single row, toggling weight valid
        start_job(8'd1);
        for (int i = 0; i < 8; i++) begin
            wt_valid = vt[i].wv;
            wt_in    = vt[i].wt;
            #1;
            chk($sformatf("v%0d_arr_control", i), arr_control, vt[i].exp_ctrl);
            chk($sformatf("v%0d_arr_wt", i), arr_wt, vt[i].exp_wt);
            chk($sformatf("v%0d_wt_ready", i), wt_ready, vt[i].exp_wready);
            chk($sformatf("v%0d_data_ready", i), data_ready, vt[i].exp_dready);
            step();
        end
        wt_valid = 1'b0;
        beat_watch(32'h04030201, 1'b1);

        // Three rows with a two-cycle gap, start re-pulsed during LOAD
        start_job(8'd3);
        start = 1'b1; num_rows = 8'd9; wt_valid = 1'b1; wt_in = 32'h01010101;
        step();
        start = 1'b0;
        repeat (3) step();
        wt_valid = 1'b0;
        prev_dv = 1'b0;
        for (int k = 0; k < 17; k++) begin
            dv         = (k == 0) || (k == 3) || (k == 4);
            data_valid = dv;
            data_in    = {8'h44, 8'h33, 8'h22, 8'(8'h10 + k)};
            arr_acc    = {4{32'h1000 + 32'(k)}};
            #1;
            chk($sformatf("g_data_ready_k%0d", k), data_ready, k <= 4);
            chk($sformatf("g_res_valid_k%0d", k), res_valid, (k == 8) || (k == 11) || (k == 12));
            if ((k == 8) || (k == 11) || (k == 12))
                chk($sformatf("g_res_data_k%0d", k), res_data, {4{32'h1000 + 32'(k - 1)}});
            chk($sformatf("g_lane0_k%0d", k), arr_data[7:0], prev_dv ? 8'(8'h10 + k - 1) : 8'h00);
            chk($sformatf("g_done_k%0d", k), done, k == 13);
            prev_dv = dv;
            step();
        end
        data_valid = 1'b0;

        // Zero-row job
        start_job(8'd0);
        load4();
        chk("z_done", done, 1'b1);
        chk("z_data_ready", data_ready, 1'b0);
        step();
        chk("z_idle", busy, 1'b0);
        any_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (res_valid || done || data_ready) any_bad = 1'b1;
            step();
        end
        chk("z_no_result", any_bad, 1'b0);

        // Reset during COMPUTE
        start_job(8'd2);
        load4();
        data_valid = 1'b1; data_in = 32'h0A0B0C0D;
        step();
        data_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("mr_outputs", {arr_control, arr_wt, arr_data, res_valid, done, busy, wt_ready, data_ready}, '0);
        chk("mr_res_data", res_data, '0);
        rst_n = 1'b1;
        any_bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (res_valid || done || busy) any_bad = 1'b1;
            step();
        end
        chk("mr_silent", any_bad, 1'b0);
        start_job(8'd1);
        load4();
        beat_watch(32'h01020304, 1'b0);

        // 255-row job must finish without counter wrap
        start_job(8'd255);
        load4();
        data_valid = 1'b1; data_in = 32'h01010101;
        nres = 0; ndone = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (res_valid) nres++;
            if (done) ndone++;
        end
        data_valid = 1'b0;
        chk("full_res_count", 128'(nres), 128'd255);
        chk("full_done_count", 128'(ndone), 128'd1);
        chk("full_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
